// File: rtl/tlp_pkg.sv
// -----------------------------------------------------------------------------
// tlp_pkg
//   Shared definitions for the PCIe-RX to XGMII-FIFO TLP packer:
//   - bit positions inside the 72-bit FIFO word
//   - TLP fmt/type codes that identify a Memory Write
//   - packer FSM state encoding
//   - small helper that turns a 4-bit keep group into a dword enable
// -----------------------------------------------------------------------------
package tlp_pkg;

    // FIFO word layout: [63:0] data, then the sideband flags, [71:69] zero.
    localparam int FIFO_W     = 72;
    localparam int FIFO_START = 64;
    localparam int FIFO_LAST  = 65;
    localparam int FIFO_EN_LO = 66;
    localparam int FIFO_EN_HI = 67;
    localparam int FIFO_IFG   = 68;

    // Header fields for a Memory Write with data, 3DW or 4DW header.
    localparam logic [1:0] FMT_3DW_D = 2'b10;
    localparam logic [1:0] FMT_4DW_D = 2'b11;
    localparam logic [4:0] TYPE_MEM  = 5'b00000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HOLD = 3'd1,
        S_FWD  = 3'd2,
        S_LAST = 3'd3,
        S_DROP = 3'd4
    } state_t;

    // A dword is valid on the FIFO side only when all four of its bytes are kept.
    function automatic logic dw_enable(input logic [3:0] i_keep);
        return (i_keep == 4'hF);
    endfunction

endpackage

// File: rtl/tlp_mwr_filter.sv
// -----------------------------------------------------------------------------
// tlp_mwr_filter
//   Purely combinational TLP inspection. The top registers the beat-0 results
//   and uses the beat-1 window hit for its forward decision.
//
//   i_tdata     current AXIS beat
//   i_is_4dw    header size recorded from beat 0 (selects the address dword)
//   i_win_base  address window base
//   i_win_mask  address window mask
//   o_is_mwr    beat 0 is a Memory Write header (3DW or 4DW)
//   o_is_4dw    beat 0 carries a 4DW header
//   o_hit       beat 1 address falls inside the window
// -----------------------------------------------------------------------------
module tlp_mwr_filter
    import tlp_pkg::*;
(
    input  logic [63:0] i_tdata,
    input  logic        i_is_4dw,
    input  logic [31:0] i_win_base,
    input  logic [31:0] i_win_mask,
    output logic        o_is_mwr,
    output logic        o_is_4dw,
    output logic        o_hit
);

    logic [1:0]  w_fmt;
    logic [4:0]  w_type;
    logic [31:0] w_addr;
    logic        w_upper_ok;

    assign w_fmt  = i_tdata[30:29];
    assign w_type = i_tdata[28:24];

    assign o_is_mwr = (w_type == TYPE_MEM) &&
                      ((w_fmt == FMT_3DW_D) || (w_fmt == FMT_4DW_D));
    assign o_is_4dw = (w_fmt == FMT_4DW_D);

    // A 4DW header puts the upper address in the low dword of beat 1; the
    // window is 32-bit, so any non-zero upper address is a miss.
    assign w_addr     = i_is_4dw ? i_tdata[63:32] : i_tdata[31:0];
    assign w_upper_ok = ~i_is_4dw | (i_tdata[31:0] == 32'h0);

    assign o_hit = w_upper_ok && ((w_addr & i_win_mask) == (i_win_base & i_win_mask));

endmodule

// File: rtl/tlp_fifo_packer.sv
// -----------------------------------------------------------------------------
// tlp_fifo_packer
//   Filters PCIe RX TLPs down to in-window Memory Writes and repacks them into
//   72-bit FIFO words for the XGMII transmit engine. One beat is always held
//   back so the final word can be tagged "last" once tlast has been seen.
//
//   pcie_clk / sys_rst      clock, synchronous active-high reset
//   s_axis_rx_*             64-bit AXI-Stream TLP input (tkeep 8'h0F or 8'hFF)
//   din / wr_en             FIFO write word and strobe (registered)
//   full / almost_full      FIFO status; almost_full gates the start of a TLP
//   fwd_en                  0 drops every TLP
//   win_base / win_mask     address window for the forward decision
//   fwd_cnt / drop_cnt      wrapping TLP statistics
// -----------------------------------------------------------------------------
module tlp_fifo_packer
    import tlp_pkg::*;
#(
    parameter int unsigned IFG_ON_LAST = 1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              pcie_clk,
    input  logic              sys_rst,
    input  logic [63:0]       s_axis_rx_tdata,
    input  logic [7:0]        s_axis_rx_tkeep,
    input  logic              s_axis_rx_tlast,
    input  logic              s_axis_rx_tvalid,
    output logic              s_axis_rx_tready,
    output logic [FIFO_W-1:0] din,
    output logic              wr_en,
    input  logic              full,
    input  logic              almost_full,
    input  logic              fwd_en,
    input  logic [31:0]       win_base,
    input  logic [31:0]       win_mask,
    output logic [CNT_W-1:0]  fwd_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    state_t r_state;
    state_t w_next_state;

    logic [63:0]       r_hold_data;
    logic [7:0]        r_hold_keep;
    logic              r_is_mwr;
    logic              r_is_4dw;
    logic [FIFO_W-1:0] r_din;
    logic              r_wr_en;
    logic [CNT_W-1:0]  r_fwd_cnt;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic              w_is_mwr;
    logic              w_is_4dw;
    logic              w_hit;
    logic              w_forward;
    logic              w_tready_fsm;
    logic              w_tready;
    logic              w_accept;
    logic              w_load_hold;
    logic              w_capture;
    logic              w_wr_req;
    logic              w_wr_start;
    logic              w_wr_last;
    logic              w_fwd_inc;
    logic              w_drop_inc;
    logic [FIFO_W-1:0] w_word;

    tlp_mwr_filter u_filter (
        .i_tdata    (s_axis_rx_tdata),
        .i_is_4dw   (r_is_4dw),
        .i_win_base (win_base),
        .i_win_mask (win_mask),
        .o_is_mwr   (w_is_mwr),
        .o_is_4dw   (w_is_4dw),
        .o_hit      (w_hit)
    );

    // Configuration is only looked at here, on the beat-1 decision.
    assign w_forward = fwd_en & r_is_mwr & w_hit;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge pcie_clk) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------------------------------------------------------- tready
    // LAST stalls the stream for the cycle the held word drains; DROP never
    // stalls because nothing is written to the FIFO.
    always_comb begin
        w_tready_fsm = 1'b0;
        case (r_state)
            S_IDLE:  w_tready_fsm = ~almost_full;
            S_HOLD:  w_tready_fsm = ~full;
            S_FWD:   w_tready_fsm = ~full;
            S_LAST:  w_tready_fsm = 1'b0;
            S_DROP:  w_tready_fsm = 1'b1;
            default: w_tready_fsm = 1'b0;
        endcase
    end

    assign w_tready = w_tready_fsm & ~sys_rst;
    assign w_accept = s_axis_rx_tvalid & w_tready;

    // ---------------------------------------------------------------- next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !s_axis_rx_tlast) w_next_state = S_HOLD;
            end
            S_HOLD: begin
                if (w_accept) begin
                    if (w_forward) w_next_state = s_axis_rx_tlast ? S_LAST : S_FWD;
                    else           w_next_state = s_axis_rx_tlast ? S_IDLE : S_DROP;
                end
            end
            S_FWD: begin
                if (w_accept && s_axis_rx_tlast) w_next_state = S_LAST;
            end
            S_LAST: begin
                if (!full) w_next_state = S_IDLE;
            end
            S_DROP: begin
                if (w_accept && s_axis_rx_tlast) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- actions
    // NOTE: every signal written here gets a default first so no path infers a latch.
    always_comb begin
        w_load_hold = 1'b0;
        w_capture   = 1'b0;
        w_wr_req    = 1'b0;
        w_wr_start  = 1'b0;
        w_wr_last   = 1'b0;
        w_fwd_inc   = 1'b0;
        w_drop_inc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_load_hold = w_accept;
                w_capture   = w_accept;
                w_drop_inc  = w_accept & s_axis_rx_tlast;
            end
            S_HOLD: begin
                if (w_accept) begin
                    if (w_forward) begin
                        w_wr_req    = 1'b1;
                        w_wr_start  = 1'b1;
                        w_load_hold = 1'b1;
                    end else begin
                        w_drop_inc  = s_axis_rx_tlast;
                    end
                end
            end
            S_FWD: begin
                w_wr_req    = w_accept;
                w_load_hold = w_accept;
            end
            S_LAST: begin
                if (!full) begin
                    w_wr_req  = 1'b1;
                    w_wr_last = 1'b1;
                    w_fwd_inc = 1'b1;
                end
            end
            S_DROP: begin
                w_drop_inc = w_accept & s_axis_rx_tlast;
            end
            default: ;
        endcase
    end

    // The FIFO word is always built from the held beat, never the live one.
    always_comb begin
        w_word             = '0;
        w_word[63:0]       = r_hold_data;
        w_word[FIFO_START] = w_wr_start;
        w_word[FIFO_LAST]  = w_wr_last;
        w_word[FIFO_EN_LO] = dw_enable(r_hold_keep[3:0]);
        w_word[FIFO_EN_HI] = dw_enable(r_hold_keep[7:4]);
        w_word[FIFO_IFG]   = w_wr_last & (IFG_ON_LAST != 0);
    end

    // ---------------------------------------------------------------- datapath
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge pcie_clk) begin
        if (sys_rst) begin
            r_hold_data <= '0;
            r_hold_keep <= '0;
            r_is_mwr    <= 1'b0;
            r_is_4dw    <= 1'b0;
            r_din       <= '0;
            r_wr_en     <= 1'b0;
            r_fwd_cnt   <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_wr_en <= w_wr_req;
            if (w_wr_req) begin
                r_din <= w_word;
            end
            // Hold only changes on an accepted beat, so a stall leaves it intact.
            if (w_load_hold) begin
                r_hold_data <= s_axis_rx_tdata;
                r_hold_keep <= s_axis_rx_tkeep;
            end
            if (w_capture) begin
                r_is_mwr <= w_is_mwr;
                r_is_4dw <= w_is_4dw;
            end
            if (w_fwd_inc) begin
                r_fwd_cnt <= r_fwd_cnt + CNT_W'(1);
            end
            if (w_drop_inc) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    assign s_axis_rx_tready = w_tready;
    assign din              = r_din;
    assign wr_en            = r_wr_en;
    assign fwd_cnt          = r_fwd_cnt;
    assign drop_cnt         = r_drop_cnt;

endmodule

// File: tb/tb_tlp_fifo_packer.sv
// -----------------------------------------------------------------------------
// tb_tlp_fifo_packer
//   Directed bench for tlp_fifo_packer. Inputs change on the falling edge,
//   tready is sampled 1 ns before the rising edge, FIFO writes are collected
//   on the falling edge. Counters are narrowed to 4 bits so wrap is reachable.
// -----------------------------------------------------------------------------
module tb_tlp_fifo_packer;

    localparam int CNT_W = 4;

    logic             pcie_clk = 1'b0;
    logic             sys_rst;
    logic [63:0]      s_axis_rx_tdata;
    logic [7:0]       s_axis_rx_tkeep;
    logic             s_axis_rx_tlast;
    logic             s_axis_rx_tvalid;
    logic             s_axis_rx_tready;
    logic [71:0]      din;
    logic             wr_en;
    logic             full;
    logic             almost_full;
    logic             fwd_en;
    logic [31:0]      win_base;
    logic [31:0]      win_mask;
    logic [CNT_W-1:0] fwd_cnt;
    logic [CNT_W-1:0] drop_cnt;

    always #5 pcie_clk = ~pcie_clk;

    tlp_fifo_packer #(
        .IFG_ON_LAST (1),
        .CNT_W       (CNT_W)
    ) dut (
        .pcie_clk         (pcie_clk),
        .sys_rst          (sys_rst),
        .s_axis_rx_tdata  (s_axis_rx_tdata),
        .s_axis_rx_tkeep  (s_axis_rx_tkeep),
        .s_axis_rx_tlast  (s_axis_rx_tlast),
        .s_axis_rx_tvalid (s_axis_rx_tvalid),
        .s_axis_rx_tready (s_axis_rx_tready),
        .din              (din),
        .wr_en            (wr_en),
        .full             (full),
        .almost_full      (almost_full),
        .fwd_en           (fwd_en),
        .win_base         (win_base),
        .win_mask         (win_mask),
        .fwd_cnt          (fwd_cnt),
        .drop_cnt         (drop_cnt)
    );

    int          checks   = 0;
    int          failures = 0;
    int          last_stalls;
    logic [71:0] wq[$];
    logic [63:0] tlp_d[8];
    logic [7:0]  tlp_k[8];
    logic [71:0] exp_w[8];
    logic [71:0] got;

    always @(negedge pcie_clk) begin
        if (wr_en === 1'b1) wq.push_back(din);
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ stimulus
    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        last_stalls = 0;
        @(negedge pcie_clk);
        s_axis_rx_tdata  = d;
        s_axis_rx_tkeep  = k;
        s_axis_rx_tlast  = l;
        s_axis_rx_tvalid = 1'b1;
        while (!acc && n < 40) begin
            if (n > 0) @(negedge pcie_clk);
            #4;
            acc = (s_axis_rx_tready === 1'b1);
            if (!acc) last_stalls++;
            @(posedge pcie_clk);
            n++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout data=%h never accepted", d);
        end
    endtask

    // Holds full (or almost_full) high from the beat's first cycle for cyc edges.
    task automatic drive_beat_pressed(input logic [63:0] d, input logic [7:0] k, input logic l,
                                      input bit use_af, input int cyc);
        fork
            drive_beat(d, k, l);
            begin
                @(negedge pcie_clk);
                if (use_af) almost_full = 1'b1;
                else        full        = 1'b1;
                repeat (cyc) @(posedge pcie_clk);
                #1;
                almost_full = 1'b0;
                full        = 1'b0;
            end
        join
    endtask

    task automatic send_tlp(input int n);
        for (int i = 0; i < n; i++) drive_beat(tlp_d[i], tlp_k[i], i == n - 1);
    endtask

    task automatic idle(input int n);
        @(negedge pcie_clk);
        s_axis_rx_tvalid = 1'b0;
        s_axis_rx_tlast  = 1'b0;
        repeat (n) @(negedge pcie_clk);
    endtask

    task automatic do_reset(input bit clear_q);
        @(negedge pcie_clk);
        sys_rst          = 1'b1;
        s_axis_rx_tvalid = 1'b0;
        s_axis_rx_tlast  = 1'b0;
        full             = 1'b0;
        almost_full      = 1'b0;
        @(posedge pcie_clk);
        @(negedge pcie_clk);
        sys_rst = 1'b0;
        if (clear_q) wq.delete();
    endtask

    // 3DW MWr to 0x1000 with one data dword; used by several scenarios.
    task automatic load_simple_mwr();
        tlp_d[0] = {32'h0000_000F, 32'h4000_0001};  tlp_k[0] = 8'hFF;
        tlp_d[1] = {32'hDEAD_BEEF, 32'h0000_1000};  tlp_k[1] = 8'hFF;
        exp_w[0] = {8'h0D, tlp_d[0]};
        exp_w[1] = {8'h1E, tlp_d[1]};
    endtask

    // ------------------------------------------------------------ scenarios
    task automatic test_reset();
        @(negedge pcie_clk);
        sys_rst = 1'b1;
        s_axis_rx_tdata = '0; s_axis_rx_tkeep = '0; s_axis_rx_tlast = 1'b0;
        s_axis_rx_tvalid = 1'b1; full = 1'b0; almost_full = 1'b0; fwd_en = 1'b1;
        win_base = 32'h0000_1000; win_mask = 32'hFFFF_F000;
        #4;
        checks++;
        if (s_axis_rx_tready !== 1'b0) begin failures++; $display("FAIL reset_tready got=%b exp=0", s_axis_rx_tready); end
        @(posedge pcie_clk);
        @(posedge pcie_clk);
        #1;
        checks++;
        if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
        checks++;
        if (din !== 72'h0) begin failures++; $display("FAIL reset_din got=%h exp=0", din); end
        checks++;
        if (fwd_cnt !== 4'd0 || drop_cnt !== 4'd0) begin
            failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", fwd_cnt, drop_cnt);
        end
        @(negedge pcie_clk);
        s_axis_rx_tvalid = 1'b0;
        sys_rst = 1'b0;
        #4;
        checks++;
        if (s_axis_rx_tready !== 1'b1) begin failures++; $display("FAIL idle_tready got=%b exp=1", s_axis_rx_tready); end
        wq.delete();
    endtask

    task automatic test_fwd_3dw();
        do_reset(1'b1);
        load_simple_mwr();
        send_tlp(2);
        idle(4);
        checks++;
        if (wq.size() != 2) begin failures++; $display("FAIL fwd3dw_words got=%0d exp=2", wq.size()); end
        for (int i = 0; i < 2; i++) begin
            got = (i < wq.size()) ? wq[i] : 'x;
            checks++;
            if (got !== exp_w[i]) begin failures++; $display("FAIL fwd3dw_word%0d got=%h exp=%h", i, got, exp_w[i]); end
        end
        checks++;
        if (fwd_cnt !== 4'd1 || drop_cnt !== 4'd0) begin
            failures++; $display("FAIL fwd3dw_counters got=%0d/%0d exp=1/0", fwd_cnt, drop_cnt);
        end
    endtask

    task automatic test_4dw();
        do_reset(1'b1);
        tlp_d[0] = {32'h0000_00FF, 32'h6000_0002};  tlp_k[0] = 8'hFF;
        tlp_d[1] = {32'h0000_1000, 32'h0000_0001};  tlp_k[1] = 8'hFF;
        tlp_d[2] = {32'h2222_2222, 32'h1111_1111};  tlp_k[2] = 8'hFF;
        send_tlp(3);
        idle(4);
        checks++;
        if (wq.size() != 0 || drop_cnt !== 4'd1) begin
            failures++; $display("FAIL 4dw_upper_drop got words=%0d drop=%0d exp 0/1", wq.size(), drop_cnt);
        end
        // Upper address zero: forwarded. Config changes after beat 1 must not matter.
        tlp_d[1] = {32'h0000_1000, 32'h0000_0000};
        exp_w[0] = {8'h0D, tlp_d[0]};
        exp_w[1] = {8'h0C, tlp_d[1]};
        exp_w[2] = {8'h1E, tlp_d[2]};
        drive_beat(tlp_d[0], tlp_k[0], 1'b0);
        drive_beat(tlp_d[1], tlp_k[1], 1'b0);
        #1;
        win_base = 32'hFFFF_0000;
        fwd_en   = 1'b0;
        drive_beat(tlp_d[2], tlp_k[2], 1'b1);
        idle(4);
        win_base = 32'h0000_1000;
        fwd_en   = 1'b1;
        checks++;
        if (wq.size() != 3) begin failures++; $display("FAIL 4dw_words got=%0d exp=3", wq.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < wq.size()) ? wq[i] : 'x;
            checks++;
            if (got !== exp_w[i]) begin failures++; $display("FAIL 4dw_word%0d got=%h exp=%h", i, got, exp_w[i]); end
        end
        checks++;
        if (fwd_cnt !== 4'd1 || drop_cnt !== 4'd1) begin
            failures++; $display("FAIL 4dw_counters got=%0d/%0d exp=1/1", fwd_cnt, drop_cnt);
        end
    endtask

    task automatic test_drop();
        do_reset(1'b1);
        // MRd in window, then MWr outside the window, back to back.
        drive_beat({32'h0000_000F, 32'h0000_0001}, 8'hFF, 1'b0);
        drive_beat({32'h0000_0000, 32'h0000_1000}, 8'h0F, 1'b1);
        drive_beat({32'h0000_000F, 32'h4000_0003}, 8'hFF, 1'b0);
        drive_beat({32'hC0C0_0001, 32'h0000_2000}, 8'hFF, 1'b0);
        drive_beat_pressed({32'hC0C0_0003, 32'hC0C0_0002}, 8'hFF, 1'b1, 1'b0, 1);
        checks++;
        if (last_stalls != 0) begin failures++; $display("FAIL drop_tready_under_full stalls=%0d exp=0", last_stalls); end
        idle(3);
        checks++;
        if (wq.size() != 0 || drop_cnt !== 4'd2) begin
            failures++; $display("FAIL drop_two got words=%0d drop=%0d exp 0/2", wq.size(), drop_cnt);
        end
        // MWr header with tlast on beat 0.
        drive_beat({32'h0000_000F, 32'h4000_0001}, 8'hFF, 1'b1);
        idle(2);
        checks++;
        if (drop_cnt !== 4'd3) begin failures++; $display("FAIL drop_single_beat got=%0d exp=3", drop_cnt); end
        // In-window MWr with forwarding disabled.
        fwd_en = 1'b0;
        load_simple_mwr();
        send_tlp(2);
        idle(3);
        fwd_en = 1'b1;
        checks++;
        if (wq.size() != 0 || drop_cnt !== 4'd4 || fwd_cnt !== 4'd0) begin
            failures++; $display("FAIL drop_fwd_en got words=%0d drop=%0d fwd=%0d exp 0/4/0", wq.size(), drop_cnt, fwd_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b1);
        tlp_d[0] = {32'h0000_000F, 32'h4000_0008};  tlp_k[0] = 8'hFF;
        tlp_d[1] = {32'hA0A0_0001, 32'h0000_1000};  tlp_k[1] = 8'hFF;
        tlp_d[2] = {32'hA0A0_0003, 32'hA0A0_0002};  tlp_k[2] = 8'hFF;
        tlp_d[3] = {32'hA0A0_0005, 32'hA0A0_0004};  tlp_k[3] = 8'hFF;
        tlp_d[4] = {32'hA0A0_0007, 32'hA0A0_0006};  tlp_k[4] = 8'hFF;
        tlp_d[5] = {32'h0000_0000, 32'hA0A0_0008};  tlp_k[5] = 8'h0F;
        exp_w[0] = {8'h0D, tlp_d[0]};
        for (int i = 1; i < 5; i++) exp_w[i] = {8'h0C, tlp_d[i]};
        exp_w[5] = {8'h16, tlp_d[5]};
        for (int i = 0; i < 3; i++) drive_beat(tlp_d[i], tlp_k[i], 1'b0);
        drive_beat_pressed(tlp_d[3], tlp_k[3], 1'b0, 1'b0, 3);
        checks++;
        if (last_stalls != 3) begin failures++; $display("FAIL full_stall_cycles got=%0d exp=3", last_stalls); end
        drive_beat(tlp_d[4], tlp_k[4], 1'b0);
        drive_beat(tlp_d[5], tlp_k[5], 1'b1);
        idle(4);
        checks++;
        if (wq.size() != 6) begin failures++; $display("FAIL full_words got=%0d exp=6", wq.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < wq.size()) ? wq[i] : 'x;
            checks++;
            if (got !== exp_w[i]) begin failures++; $display("FAIL full_word%0d got=%h exp=%h", i, got, exp_w[i]); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b1);
        load_simple_mwr();
        drive_beat_pressed(tlp_d[0], tlp_k[0], 1'b0, 1'b1, 3);
        checks++;
        if (last_stalls != 3) begin failures++; $display("FAIL almost_full_stall got=%0d exp=3", last_stalls); end
        drive_beat(tlp_d[1], tlp_k[1], 1'b1);
        tlp_d[2] = {32'h0000_000F, 32'h4000_0001};
        tlp_d[3] = {32'h1234_5678, 32'h0000_1004};
        exp_w[2] = {8'h0D, tlp_d[2]};
        exp_w[3] = {8'h1E, tlp_d[3]};
        drive_beat(tlp_d[2], 8'hFF, 1'b0);
        checks++;
        if (last_stalls != 1) begin failures++; $display("FAIL b2b_last_stall got=%0d exp=1", last_stalls); end
        drive_beat(tlp_d[3], 8'hFF, 1'b1);
        idle(4);
        checks++;
        if (wq.size() != 4) begin failures++; $display("FAIL b2b_words got=%0d exp=4", wq.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < wq.size()) ? wq[i] : 'x;
            checks++;
            if (got !== exp_w[i]) begin failures++; $display("FAIL b2b_word%0d got=%h exp=%h", i, got, exp_w[i]); end
        end
        checks++;
        if (fwd_cnt !== 4'd2) begin failures++; $display("FAIL b2b_fwd_cnt got=%0d exp=2", fwd_cnt); end
    endtask

    task automatic test_reset_mid_tlp();
        do_reset(1'b1);
        load_simple_mwr();
        send_tlp(2);
        drive_beat({32'h0, 32'h0}, 8'hFF, 1'b1);
        idle(3);
        checks++;
        if (fwd_cnt !== 4'd1 || drop_cnt !== 4'd1) begin
            failures++; $display("FAIL midrst_pre_counters got=%0d/%0d exp=1/1", fwd_cnt, drop_cnt);
        end
        wq.delete();
        tlp_d[0] = {32'h0000_000F, 32'h4000_0006};
        tlp_d[1] = {32'hB0B0_0001, 32'h0000_1000};
        tlp_d[2] = {32'hB0B0_0003, 32'hB0B0_0002};
        for (int i = 0; i < 3; i++) drive_beat(tlp_d[i], 8'hFF, 1'b0);
        idle(3);
        checks++;
        if (wq.size() != 2) begin failures++; $display("FAIL midrst_partial_words got=%0d exp=2", wq.size()); end
        do_reset(1'b0);
        #1;
        checks++;
        if (fwd_cnt !== 4'd0 || drop_cnt !== 4'd0) begin
            failures++; $display("FAIL midrst_counters got=%0d/%0d exp=0/0", fwd_cnt, drop_cnt);
        end
        // Tail of the interrupted TLP now looks like a non-MWr TLP and drops.
        drive_beat({32'h4444_4444, 32'h3333_3333}, 8'hFF, 1'b0);
        drive_beat({32'h5555_5555, 32'h5555_5555}, 8'hFF, 1'b1);
        idle(4);
        checks++;
        if (wq.size() != 2 || drop_cnt !== 4'd1 || fwd_cnt !== 4'd0) begin
            failures++; $display("FAIL midrst_tail got words=%0d drop=%0d fwd=%0d exp 2/1/0", wq.size(), drop_cnt, fwd_cnt);
        end
        wq.delete();
        load_simple_mwr();
        send_tlp(2);
        idle(4);
        checks++;
        if (wq.size() != 2) begin failures++; $display("FAIL midrst_next_words got=%0d exp=2", wq.size()); end
        for (int i = 0; i < 2; i++) begin
            got = (i < wq.size()) ? wq[i] : 'x;
            checks++;
            if (got !== exp_w[i]) begin failures++; $display("FAIL midrst_next_word%0d got=%h exp=%h", i, got, exp_w[i]); end
        end
        checks++;
        if (fwd_cnt !== 4'd1) begin failures++; $display("FAIL midrst_next_fwd got=%0d exp=1", fwd_cnt); end
    endtask

    task automatic test_counter_wrap();
        do_reset(1'b1);
        for (int i = 0; i < 15; i++) drive_beat({32'h0, 32'h4000_0001}, 8'hFF, 1'b1);
        idle(2);
        checks++;
        if (drop_cnt !== 4'hF) begin failures++; $display("FAIL wrap_pre got=%0d exp=15", drop_cnt); end
        drive_beat({32'h0, 32'h4000_0001}, 8'hFF, 1'b1);
        idle(2);
        checks++;
        if (drop_cnt !== 4'h0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", drop_cnt); end
        drive_beat({32'h0, 32'h4000_0001}, 8'hFF, 1'b1);
        idle(2);
        checks++;
        if (drop_cnt !== 4'h1 || wq.size() != 0) begin
            failures++; $display("FAIL wrap_one got drop=%0d words=%0d exp 1/0", drop_cnt, wq.size());
        end
    endtask

    initial begin
        test_reset();
        test_fwd_3dw();
        test_4dw();
        test_drop();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_tlp();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
